// File: rtl/clock_gen_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen_ctrl_if
// Brief    : Control/status bundle for clock_gen_ctrl. The burst_len signal
//            exists only when CLKGEN_BURST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_gen_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_half;
    logic             start;
    logic             stop;
`ifdef CLKGEN_BURST_EN
    logic [CNT_W-1:0] burst_len;
`endif
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             done;

    // Reject degenerate widths at elaboration
    if (DIV_W < 1 || CNT_W < 1) begin : g_bad_width
        $error("clock_gen_ctrl_if: DIV_W and CNT_W must be at least 1");
    end

`ifdef CLKGEN_BURST_EN
    modport master (
        output cfg_valid, cfg_half, start, stop, burst_len,
        input  cfg_ready, clk_out, tick, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_half, start, stop, burst_len,
        output cfg_ready, clk_out, tick, busy, done
    );
`else
    modport master (
        output cfg_valid, cfg_half, start, stop,
        input  cfg_ready, clk_out, tick, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_half, start, stop,
        output cfg_ready, clk_out, tick, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/clock_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen_ctrl
// Brief    : Programmable divided-clock generator. Produces a registered
//            square wave of period 2*half_q with a one-cycle tick on every
//            edge of clk_out, glitch-free stop (high phase never shortened)
//            and, when CLKGEN_BURST_EN is defined, a limit on the number
//            of periods per start.
// Macro    : CLKGEN_BURST_EN - enables burst_len port and burst counter.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gen_ctrl #(
    parameter int DIV_W    = 16,
    parameter int CNT_W    = 16,
    parameter int RST_HALF = 5
) (
    input  logic           clk,
    input  logic           rst,
    clock_gen_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    // A zero half-period would never reach its terminal count, so store 1
    localparam logic [DIV_W-1:0] c_RST_HALF = (RST_HALF == 0) ? DIV_W'(1) : DIV_W'(RST_HALF);
    localparam logic [DIV_W-1:0] c_ONE      = DIV_W'(1);

    // Reject degenerate widths at elaboration
    if (DIV_W < 1 || CNT_W < 1) begin : g_bad_width
        $error("clock_gen_ctrl: DIV_W and CNT_W must be at least 1");
    end

    state_t           r_state;
    logic [DIV_W-1:0] r_half;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_done;

    logic             w_terminal;
    logic             w_cfg_fire;
    logic [DIV_W-1:0] w_half_new;
    logic             w_burst_end;

    assign w_terminal = (r_cnt == (r_half - c_ONE));
    assign w_cfg_fire = bus.cfg_valid && (r_state == S_IDLE);
    assign w_half_new = (bus.cfg_half == '0) ? c_ONE : bus.cfg_half;

`ifdef CLKGEN_BURST_EN
    logic [CNT_W-1:0] r_blen;
    logic [CNT_W-1:0] r_bcnt;

    // Burst completes on the fall that closes period r_blen; 0 = unlimited
    assign w_burst_end = (r_blen != '0) && (r_bcnt >= r_blen);

    // Latch the burst limit at start and count rising edges (saturating)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blen <= '0;
            r_bcnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.start && !bus.stop) begin
                r_blen <= bus.burst_len;
                r_bcnt <= '0;
            end
        end else if (r_state == S_RUN && !bus.stop && w_terminal && !r_clk_out) begin
            if (r_bcnt != '1) begin
                r_bcnt <= r_bcnt + CNT_W'(1);
            end
        end
    end
`else
    assign w_burst_end = 1'b0;
`endif

    // Main sequencer: config capture, divider counter, clk_out/tick/done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_half    <= c_RST_HALF;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;

            if (w_cfg_fire) begin
                r_half <= w_half_new;
            end

            case (r_state)
                S_IDLE: begin
                    r_clk_out <= 1'b0;
                    // stop outranks start: a simultaneous pair does nothing
                    if (bus.start && !bus.stop) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end
                end

                S_RUN: begin
                    if (bus.stop && !r_clk_out) begin
                        // Low phase may be cut short without a glitch
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else if (w_terminal) begin
                        r_cnt     <= '0;
                        r_clk_out <= ~r_clk_out;
                        r_tick    <= 1'b1;
                        // Falling toggle: finish here if stopping or burst is complete
                        if (r_clk_out && (bus.stop || w_burst_end)) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                        // High phase must complete before stopping
                        if (bus.stop) begin
                            r_state <= S_STOPPING;
                        end
                    end
                end

                S_STOPPING: begin
                    if (w_terminal) begin
                        r_cnt     <= '0;
                        r_clk_out <= 1'b0;
                        r_tick    <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_out   = r_clk_out;
    assign bus.tick      = r_tick;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.cfg_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clock_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gen_ctrl
// Brief    : Scoreboard bench for clock_gen_ctrl. The stimulus process feeds
//            a closed-form reference model (phase = floor(k/half) parity)
//            and queues the expected post-edge outputs; a monitor on the
//            falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gen_ctrl;

    localparam int c_DIV_W    = 16;
    localparam int c_CNT_W    = 16;
    localparam int c_RST_HALF = 5;

    logic clk;
    logic rst;

    clock_gen_ctrl_if #(.DIV_W(c_DIV_W), .CNT_W(c_CNT_W)) bus ();

    clock_gen_ctrl #(
        .DIV_W    (c_DIV_W),
        .CNT_W    (c_CNT_W),
        .RST_HALF (c_RST_HALF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit clk_out;
        bit tick;
        bit busy;
        bit done;
        bit cfg_ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (touched only by the stimulus process)
    bit m_run;
    int m_k;        // edges since the start edge
    int m_h;        // half-period in use for this run
    int m_half;     // configured half-period
    int m_blen;     // burst length, 0 = unlimited
    int m_stop_end; // edge index at which a requested stop completes, -1 none
    bit m_clk;      // expected clk_out after the latest edge

    // Apply one edge's sampled inputs to the model and queue the expectation
    task automatic model_edge(input bit r, input bit cv, input int ch,
                              input bit st, input bit sp, input int bl);
        exp_t e;
        bit   prev;
        int   burst_end;
        e = '{clk_out: 1'b0, tick: 1'b0, busy: 1'b0, done: 1'b0, cfg_ready: 1'b1};
        if (r) begin
            m_run  = 1'b0;
            m_half = c_RST_HALF;
        end else if (!m_run) begin
            if (cv) m_half = (ch == 0) ? 1 : ch;
            if (st && !sp) begin
                m_run      = 1'b1;
                m_k        = 0;
                m_h        = m_half;
`ifdef CLKGEN_BURST_EN
                m_blen     = bl;
`else
                m_blen     = 0;
`endif
                m_stop_end = -1;
                e.busy      = 1'b1;
                e.cfg_ready = 1'b0;
            end
        end else begin
            m_k++;
            prev      = (((m_k - 1) / m_h) % 2) == 1;
            burst_end = (m_blen == 0) ? -1 : 2 * m_h * m_blen;
            if (sp && m_stop_end < 0) begin
                if (!prev) m_stop_end = m_k;
                else       m_stop_end = 2 * m_h * ((m_k + 2 * m_h - 1) / (2 * m_h));
            end
            if (m_k == m_stop_end && !prev) begin
                e.done = 1'b1;
                m_run  = 1'b0;
            end else if (m_k == m_stop_end || m_k == burst_end) begin
                e.done = 1'b1;
                e.tick = 1'b1;
                m_run  = 1'b0;
            end else begin
                e.busy      = 1'b1;
                e.cfg_ready = 1'b0;
                e.clk_out   = ((m_k / m_h) % 2) == 1;
                e.tick      = (m_k % m_h) == 0;
            end
        end
        m_clk = e.clk_out;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge happen, record the expectation
    task automatic cyc(input bit r, input bit cv, input int ch,
                       input bit st, input bit sp, input int bl);
        rst           = r;
        bus.cfg_valid = cv;
        bus.cfg_half  = c_DIV_W'(ch);
        bus.start     = st;
        bus.stop      = sp;
`ifdef CLKGEN_BURST_EN
        bus.burst_len = c_CNT_W'(bl);
`endif
        @(posedge clk);
        model_edge(r, cv, ch, st, sp, bl);
        #1;
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Idle until the model reports the run is over, with a cycle budget
    task automatic wait_idle();
        int n;
        n = 0;
        while (m_run && n < 400) begin
            cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (m_run) begin
            errors++;
            $display("FAIL wait_idle: still running after %0d cycles, required idle", n);
        end
        idle_cycles(1);
    endtask

    task automatic run_until_clk(input bit level);
        int n;
        n = 0;
        while (m_clk != level && n < 100) begin
            cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
    endtask

    task automatic chk(input string name, input bit act, input bit req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the queued model result each cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("clk_out",   bus.clk_out,   e.clk_out);
            chk("tick",      bus.tick,      e.tick);
            chk("busy",      bus.busy,      e.busy);
            chk("done",      bus.done,      e.done);
            chk("cfg_ready", bus.cfg_ready, e.cfg_ready);
        end
    end

    initial begin
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_half  = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
`ifdef CLKGEN_BURST_EN
        bus.burst_len = '0;
`endif
        m_run = 1'b0; m_k = 0; m_h = 1; m_half = c_RST_HALF;
        m_blen = 0; m_stop_end = -1; m_clk = 1'b0;

        // Reset defaults, then start with the reset half-period
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle_cycles(2);
        cyc(0, 0, 0, 1, 0, 0);
        idle_cycles(25);
        cyc(0, 0, 0, 0, 1, 0);
        wait_idle();

        // Half 3: stop one cycle after the rise, high phase must complete
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        run_until_clk(1'b1);
        cyc(0, 0, 0, 0, 1, 0);
        wait_idle();

        // Half 0 stored as 1, stop while low
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle_cycles(5);
        run_until_clk(1'b0);
        cyc(0, 0, 0, 0, 1, 0);
        wait_idle();

        // Simultaneous start+stop in IDLE, then config ignored during RUN
        cyc(0, 0, 0, 1, 1, 0);
        idle_cycles(3);
        cyc(0, 1, 2, 1, 0, 0);
        idle_cycles(3);
        cyc(0, 1, 9, 0, 0, 0);
        idle_cycles(12);
        cyc(0, 0, 0, 0, 1, 0);
        wait_idle();

        // Reset while clk_out is high, then a run at the reset half-period
        cyc(0, 1, 4, 1, 0, 0);
        run_until_clk(1'b1);
        cyc(1, 0, 0, 0, 0, 0);
        idle_cycles(2);
        cyc(0, 0, 0, 1, 0, 0);
        idle_cycles(22);
        cyc(0, 0, 0, 0, 1, 0);
        wait_idle();

`ifdef CLKGEN_BURST_EN
        // Burst of 4 periods at half 2
        cyc(0, 1, 2, 1, 0, 4);
        idle_cycles(20);
        wait_idle();
`endif

        // Randomized runs: config+start, noisy inputs during run, stop or reset
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(0, 40);
            cyc(0, $urandom_range(0, 1), $urandom_range(0, 6), 1, 0, $urandom_range(0, 5));
            for (int i = 0; i < len; i++) begin
                cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                    $urandom_range(0, 1), 0, $urandom_range(0, 5));
            end
            if ($urandom_range(0, 7) == 0) cyc(1, 0, 0, 0, 0, 0);
            else                           cyc(0, 0, 0, $urandom_range(0, 1), 1, 0);
            wait_idle();
            idle_cycles($urandom_range(0, 2));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_gen_ctrl.md
# clock_gen_ctrl

Programmable clock-generation controller producing the divided square-wave clock and per-toggle enable used by the team's clocked test structures. It replaces free-running fixed-delay clock toggling with a synthesizable, cycle-counted generator that can be configured, started, stopped glitch-free, and optionally limited to a fixed burst. It sits between the system clock and any block needing a slow derived clock or tick.

## Interface
- Parameters:
  - `DIV_W`, 16: width of half-period configuration.
  - `CNT_W`, 16: width of burst length and burst counter.
  - `RST_HALF`, 5: half-period, in `clk` cycles, loaded at reset.
- Ports:
  - One clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock; all state updates on rising edge.
  - `rst`  in  1  synchronous active-high reset.
  - `cfg_valid`  in  1  half-period update request.
  - `cfg_ready`  out  1  high when a config is accepted (IDLE only).
  - `cfg_half`  in  DIV_W  new half-period in `clk` cycles.
  - `start`  in  1  begin generation (IDLE only).
  - `stop`  in  1  request glitch-free stop.
  - `burst_len`  in  CNT_W  period count limit; present only with `CLKGEN_BURST_EN`.
  - `clk_out`  out  1  generated clock, registered.
  - `tick`  out  1  one-cycle pulse in the cycle `clk_out` shows a new value.
  - `busy`  out  1  state != IDLE.
  - `done`  out  1  one-cycle pulse on return to IDLE after running.

## Operation
- Reset values: `clk_out`=0, `tick`=0, `busy`=0, `done`=0, `cfg_ready`=1, state IDLE, `half_q`=`RST_HALF`, counters 0.
- Config: handshake when `cfg_valid && cfg_ready`; `half_q` <= `cfg_half`, with 0 stored as 1. `cfg_ready` = (state==IDLE). Configs outside IDLE are ignored.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: `clk_out` held 0. `start` goes to RUN with `cnt`<=0.
  - RUN: `start` is ignored.
    - Each edge, if `cnt`==`half_q`-1, then toggle `clk_out`, pulse `tick`, and set `cnt`<=0.
    - Otherwise `cnt`<=`cnt`+1.
    - Period is 2·`half_q` cycles.
  - `stop` in RUN with `clk_out`=0: go to IDLE next edge. The low phase is truncated, `done`=1, and there is no `tick`.
  - `stop` in RUN with `clk_out`=1: go to STOPPING. Counting continues until the falling toggle. At that edge `clk_out`<=0, `tick`=1, `done`=1, and state<=IDLE. A high phase is never shortened.
  - STOPPING: further `stop` has no effect.
- Priority: `rst` > `stop` > `start`.
  - `start` and `stop` in the same IDLE cycle: stay IDLE, no `done`.
  - `cfg_valid` and `start` in the same IDLE cycle: the config is accepted, and RUN uses the new `half_q`.
- Reset mid-operation: all registers return to reset values next edge, including `half_q`=`RST_HALF`. No `done` is generated.
- Arithmetic: `cnt` is DIV_W bits and compares against `half_q`-1. `half_q`≥1 is guaranteed, so there is no underflow. The burst counter saturates, never wraps.

## Timing
- `start` sampled at edge E0:
  - `busy` high from E0.
  - First `clk_out` rise and `tick` at edge E`half_q`.
  - Fall at E(2·`half_q`).
- `tick` is coincident with each `clk_out` change, exactly one cycle wide.
- `done` is high in the same cycle `busy` drops.
- `cfg_ready` is low from E0 until the cycle after return to IDLE.

## Configuration
- Macro: `CLKGEN_BURST_EN`.
- Defined:
  - `burst_len` port exists and is sampled at the `start` edge.
  - Rising edges of `clk_out` are counted.
  - The falling toggle that completes period `burst_len` returns to IDLE with `done`.
  - `burst_len`=0 means unlimited.
  - `stop` still takes precedence and follows normal stop rules.
- Undefined:
  - No `burst_len` port and no burst counter.
  - Runs until `stop` or `rst`.

## Test plan
- Reset defaults: `rst` then `start` with no config -> `clk_out` rises 5 cycles after the start edge, period 10, and `tick` pulses every 5 cycles. `cfg_ready`=0 while busy.
- `cfg_half`=3, `start`, `stop` one cycle after `clk_out` rises -> high phase lasts the full 3 cycles. Then `clk_out` falls, `done`=1 for one cycle, and `busy`=0 in that cycle.
- `cfg_half`=0 -> `clk_out` toggles every cycle (period 2). Then `stop` while `clk_out`=0 -> IDLE next edge with `done`.
- Same-cycle `start`+`stop` in IDLE -> no activity and no `done`. Also, `cfg_valid` with `cfg_half`=9 during RUN -> ignored, and the period is unchanged.
- `rst` mid-RUN with `clk_out`=1 -> next cycle `clk_out`=0, `busy`=0, no `done`. A subsequent run uses half-period 5.
- With `CLKGEN_BURST_EN`: `cfg_half`=2, `burst_len`=4 -> exactly 4 rises. `done` at edge E16 after start, then `clk_out` is held 0.
